// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: drives a valid/ready data-memory request and byte-aligns/extends load data.
// Optional: define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module load_store_unit #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [4:0] LOAD_TYPE  = 5'b00000,
  parameter logic [4:0] STORE_TYPE = 5'b01000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Valid_In,
  input  logic [31:0]           Inst_In,
  input  logic [4:0]            Inst_Type_In,
  input  logic [31:0]           Addr_Result_In,
  input  logic [31:0]           Store_Data_In,
  output logic                  Stall_Out,
  output logic                  Valid_Out,
  output logic [31:0]           Inst_Out,
  output logic [31:0]           Register_Data_Out,
  output logic                  Misalign_Out,
  output logic                  Mem_Req_Valid_Out,
  input  logic                  Mem_Req_Ready_In,
  output logic                  Mem_Req_Write_Out,
  output logic [ADDR_WIDTH-1:0] Mem_Req_Addr_Out,
  output logic [31:0]           Mem_Req_Wdata_Out,
  output logic [3:0]            Mem_Req_Byte_En_Out,
  input  logic                  Mem_Rsp_Valid_In,
  input  logic [31:0]           Mem_Rsp_Data_In
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      r_state, w_next_state;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_pend_inst;

  logic        w_is_load, w_is_store, w_mem_op, w_trap, w_stall;
  logic [2:0]  w_funct3;
  logic [1:0]  w_size, w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Access size: 0 byte, 1 half, 2 word; unknown funct3 codes fall back to word.
  function automatic logic [1:0] f_size(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      case (f3)
        3'b000:  f_size = 2'd0;
        3'b001:  f_size = 2'd1;
        default: f_size = 2'd2;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: f_size = 2'd0;
        3'b001, 3'b101: f_size = 2'd1;
        default:        f_size = 2'd2;
      endcase
    end
  endfunction

  function automatic logic [31:0] f_load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  f_load_extend = {{24{b[7]}}, b};
      3'b100:  f_load_extend = {24'h000000, b};
      3'b001:  f_load_extend = {{16{h[15]}}, h};
      3'b101:  f_load_extend = {16'h0000, h};
      default: f_load_extend = word;
    endcase
  endfunction

  assign w_funct3   = Inst_In[14:12];
  assign w_is_load  = (Inst_Type_In == LOAD_TYPE);
  assign w_is_store = (Inst_Type_In == STORE_TYPE);
  assign w_mem_op   = w_is_load || w_is_store;
  assign w_size     = f_size(w_is_store, w_funct3);

  // Byte offset aligned down to the access size; lane data replicated for the chosen size.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = Store_Data_In;
    case (w_size)
      2'd0: begin
        w_off   = Addr_Result_In[1:0];
        w_wdata = {4{Store_Data_In[7:0]}};
      end
      2'd1: begin
        w_off   = {Addr_Result_In[1], 1'b0};
        w_wdata = {2{Store_Data_In[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_wdata = Store_Data_In;
      end
    endcase
    if (w_is_store) begin
      case (w_size)
        2'd0:    w_be = 4'b0001 << w_off;
        2'd1:    w_be = w_off[1] ? 4'b1100 : 4'b0011;
        default: w_be = 4'b1111;
      endcase
    end else begin
      w_be = 4'b1111;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign;
  assign w_misalign = ((w_size == 2'd1) && Addr_Result_In[0]) ||
                      ((w_size == 2'd2) && (Addr_Result_In[1:0] != 2'b00));
  assign w_trap = Valid_In && w_mem_op && w_misalign;

  always_ff @(posedge Clk) begin
    if (Reset) r_misalign <= 1'b0;
    else       r_misalign <= (r_state == S_IDLE) && w_trap;
  end
  assign Misalign_Out = r_misalign;
`else
  assign w_trap       = 1'b0;
  assign Misalign_Out = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state; stall drops in the completing cycle so upstream can advance.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Valid_In && w_mem_op && !w_trap) begin
          w_next_state = S_REQ;
          w_stall      = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (Mem_Req_Ready_In) begin
          w_next_state = r_is_load ? S_WAIT : S_IDLE;
          w_stall      = r_is_load;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_WAIT: begin
        if (Mem_Rsp_Valid_In) begin
          w_next_state = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end
  assign Stall_Out = w_stall;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Valid_Out           <= 1'b0;
      Inst_Out            <= 32'h0;
      Register_Data_Out   <= 32'h0;
      Mem_Req_Valid_Out   <= 1'b0;
      Mem_Req_Write_Out   <= 1'b0;
      Mem_Req_Addr_Out    <= '0;
      Mem_Req_Wdata_Out   <= 32'h0;
      Mem_Req_Byte_En_Out <= 4'h0;
      r_is_load           <= 1'b0;
      r_funct3            <= 3'b000;
      r_off               <= 2'b00;
      r_pend_inst         <= 32'h0;
    end else begin
      Valid_Out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Valid_In && w_trap) begin
            Valid_Out         <= 1'b1;
            Inst_Out          <= Inst_In;
            Register_Data_Out <= 32'h0;
          end else if (Valid_In && w_mem_op) begin
            Mem_Req_Valid_Out   <= 1'b1;
            Mem_Req_Write_Out   <= w_is_store;
            Mem_Req_Addr_Out    <= Addr_Result_In[ADDR_WIDTH+1:2];
            Mem_Req_Wdata_Out   <= w_wdata;
            Mem_Req_Byte_En_Out <= w_be;
            r_is_load           <= w_is_load;
            r_funct3            <= w_funct3;
            r_off               <= w_off;
            r_pend_inst         <= Inst_In;
          end else if (Valid_In) begin
            Valid_Out         <= 1'b1;
            Inst_Out          <= Inst_In;
            Register_Data_Out <= Addr_Result_In;
          end else begin
            Valid_Out <= 1'b0;
          end
        end
        S_REQ: begin
          if (Mem_Req_Ready_In) begin
            Mem_Req_Valid_Out <= 1'b0;
            if (!r_is_load) begin
              Valid_Out         <= 1'b1;
              Inst_Out          <= r_pend_inst;
              Register_Data_Out <= 32'h0;
            end else begin
              Valid_Out <= 1'b0;
            end
          end else begin
            Mem_Req_Valid_Out <= 1'b1;
          end
        end
        S_WAIT: begin
          if (Mem_Rsp_Valid_In) begin
            Valid_Out         <= 1'b1;
            Inst_Out          <= r_pend_inst;
            Register_Data_Out <= f_load_extend(Mem_Rsp_Data_In, r_funct3, r_off);
          end else begin
            Valid_Out <= 1'b0;
          end
        end
        default: Mem_Req_Valid_Out <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (honours MISALIGN_TRAP_EN when defined).
module tb_load_store_unit;

  localparam logic [4:0] LOAD_T  = 5'b00000;
  localparam logic [4:0] STORE_T = 5'b01000;

  logic        clk_s = 1'b0;
  logic        reset_s, valid_in_s, mem_req_ready_s, mem_rsp_valid_s;
  logic [31:0] inst_in_s, addr_s, store_data_s, mem_rsp_data_s;
  logic [4:0]  inst_type_s;
  logic        stall_s, valid_out_s, misalign_s, mem_req_valid_s, mem_req_write_s;
  logic [31:0] inst_out_s, reg_data_s, mem_req_wdata_s;
  logic [9:0]  mem_req_addr_s;
  logic [3:0]  mem_req_be_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_s = ~clk_s;

  load_store_unit dut (
    .Clk(clk_s), .Reset(reset_s), .Valid_In(valid_in_s), .Inst_In(inst_in_s),
    .Inst_Type_In(inst_type_s), .Addr_Result_In(addr_s), .Store_Data_In(store_data_s),
    .Stall_Out(stall_s), .Valid_Out(valid_out_s), .Inst_Out(inst_out_s),
    .Register_Data_Out(reg_data_s), .Misalign_Out(misalign_s),
    .Mem_Req_Valid_Out(mem_req_valid_s), .Mem_Req_Ready_In(mem_req_ready_s),
    .Mem_Req_Write_Out(mem_req_write_s), .Mem_Req_Addr_Out(mem_req_addr_s),
    .Mem_Req_Wdata_Out(mem_req_wdata_s), .Mem_Req_Byte_En_Out(mem_req_be_s),
    .Mem_Rsp_Valid_In(mem_rsp_valid_s), .Mem_Rsp_Data_In(mem_rsp_data_s)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] opc);
    mk_inst = {17'h00000, f3, 5'h01, opc};
  endfunction

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rsp, input int delay, input logic [9:0] exp_waddr,
                         input logic [31:0] exp_data);
    valid_in_s = 1'b1; inst_type_s = LOAD_T; inst_in_s = mk_inst(f3, 7'b0000011); addr_s = addr;
    #1 check_value({tag, "_stall_accept"}, {31'h0, stall_s}, 32'h1);
    tick();
    valid_in_s = 1'b0;
    check_value({tag, "_req_valid"}, {31'h0, mem_req_valid_s}, 32'h1);
    check_value({tag, "_req_write"}, {31'h0, mem_req_write_s}, 32'h0);
    check_value({tag, "_req_addr"}, {22'h0, mem_req_addr_s}, {22'h0, exp_waddr});
    check_value({tag, "_req_be"}, {28'h0, mem_req_be_s}, 32'hF);
    mem_req_ready_s = 1'b1;
    tick();
    mem_req_ready_s = 1'b0;
    check_value({tag, "_req_dropped"}, {31'h0, mem_req_valid_s}, 32'h0);
    for (int i = 0; i < delay; i++) begin
      #1 check_value({tag, "_stall_wait"}, {31'h0, stall_s}, 32'h1);
      tick();
    end
    mem_rsp_valid_s = 1'b1; mem_rsp_data_s = rsp;
    #1 check_value({tag, "_stall_rsp"}, {31'h0, stall_s}, 32'h0);
    tick();
    mem_rsp_valid_s = 1'b0;
    check_value({tag, "_valid"}, {31'h0, valid_out_s}, 32'h1);
    check_value({tag, "_data"}, reg_data_s, exp_data);
    check_value({tag, "_inst"}, inst_out_s, mk_inst(f3, 7'b0000011));
    tick();
    check_value({tag, "_pulse"}, {31'h0, valid_out_s}, 32'h0);
  endtask

  initial begin
    reset_s = 1'b1; valid_in_s = 1'b0; inst_in_s = 32'h0; inst_type_s = 5'h0;
    addr_s = 32'h0; store_data_s = 32'h0; mem_req_ready_s = 1'b0;
    mem_rsp_valid_s = 1'b0; mem_rsp_data_s = 32'h0;
    tick(); tick();
    check_value("rst_valid", {31'h0, valid_out_s}, 32'h0);
    check_value("rst_data", reg_data_s, 32'h0);
    check_value("rst_inst", inst_out_s, 32'h0);
    check_value("rst_req_valid", {31'h0, mem_req_valid_s}, 32'h0);
    check_value("rst_be", {28'h0, mem_req_be_s}, 32'h0);
    check_value("rst_misalign", {31'h0, misalign_s}, 32'h0);
    check_value("rst_stall", {31'h0, stall_s}, 32'h0);
    reset_s = 1'b0;
    tick();

    // Bypass of an ALU result
    valid_in_s = 1'b1; inst_type_s = 5'b01100; inst_in_s = 32'h00000033; addr_s = 32'h1234;
    #1 check_value("byp_stall", {31'h0, stall_s}, 32'h0);
    tick();
    valid_in_s = 1'b0;
    check_value("byp_valid", {31'h0, valid_out_s}, 32'h1);
    check_value("byp_data", reg_data_s, 32'h1234);
    check_value("byp_inst", inst_out_s, 32'h00000033);
    check_value("byp_req_valid", {31'h0, mem_req_valid_s}, 32'h0);
    tick();
    check_value("byp_pulse", {31'h0, valid_out_s}, 32'h0);

    // SB to 0x13 with ready held low for three cycles
    valid_in_s = 1'b1; inst_type_s = STORE_T; inst_in_s = mk_inst(3'b000, 7'b0100011);
    addr_s = 32'h13; store_data_s = 32'hAABBCCDD;
    #1 check_value("sb_stall_accept", {31'h0, stall_s}, 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_value("sb_req_valid", {31'h0, mem_req_valid_s}, 32'h1);
      check_value("sb_req_write", {31'h0, mem_req_write_s}, 32'h1);
      check_value("sb_req_addr", {22'h0, mem_req_addr_s}, 32'h4);
      check_value("sb_req_be", {28'h0, mem_req_be_s}, 32'h8);
      check_value("sb_req_wdata", mem_req_wdata_s, 32'hDDDDDDDD);
      check_value("sb_stall_hold", {31'h0, stall_s}, 32'h1);
      check_value("sb_no_valid", {31'h0, valid_out_s}, 32'h0);
      tick();
    end
    mem_req_ready_s = 1'b1;
    #1 check_value("sb_stall_done", {31'h0, stall_s}, 32'h0);
    tick();
    mem_req_ready_s = 1'b0; valid_in_s = 1'b0;
    check_value("sb_valid", {31'h0, valid_out_s}, 32'h1);
    check_value("sb_data", reg_data_s, 32'h0);
    check_value("sb_req_dropped", {31'h0, mem_req_valid_s}, 32'h0);
    tick();
    check_value("sb_pulse", {31'h0, valid_out_s}, 32'h0);

    // SH to 0x6 and SW to 0x8
    valid_in_s = 1'b1; inst_in_s = mk_inst(3'b001, 7'b0100011); addr_s = 32'h6;
    store_data_s = 32'h1234ABCD;
    tick();
    valid_in_s = 1'b0;
    check_value("sh_be", {28'h0, mem_req_be_s}, 32'hC);
    check_value("sh_wdata", mem_req_wdata_s, 32'hABCDABCD);
    mem_req_ready_s = 1'b1;
    tick();
    mem_req_ready_s = 1'b0;
    check_value("sh_valid", {31'h0, valid_out_s}, 32'h1);
    valid_in_s = 1'b1; inst_in_s = mk_inst(3'b010, 7'b0100011); addr_s = 32'h8;
    tick();
    valid_in_s = 1'b0;
    check_value("sw_be", {28'h0, mem_req_be_s}, 32'hF);
    check_value("sw_wdata", mem_req_wdata_s, 32'h1234ABCD);
    check_value("sw_addr", {22'h0, mem_req_addr_s}, 32'h2);
    mem_req_ready_s = 1'b1;
    tick();
    mem_req_ready_s = 1'b0;
    tick();

    do_load("lb",  3'b000, 32'h2, 32'h00800000, 0, 10'd0, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h2, 32'h00800000, 0, 10'd0, 32'h00000080);
    do_load("lh",  3'b001, 32'h6, 32'h80010000, 5, 10'd1, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h4, 32'h0000F00D, 1, 10'd1, 32'h0000F00D);
    do_load("lw",  3'b010, 32'hFF8, 32'hCAFEF00D, 2, 10'd1022, 32'hCAFEF00D);

`ifdef MISALIGN_TRAP_EN
    valid_in_s = 1'b1; inst_type_s = LOAD_T; inst_in_s = mk_inst(3'b010, 7'b0000011); addr_s = 32'h5;
    #1 check_value("mis_stall", {31'h0, stall_s}, 32'h0);
    tick();
    valid_in_s = 1'b0;
    check_value("mis_flag", {31'h0, misalign_s}, 32'h1);
    check_value("mis_valid", {31'h0, valid_out_s}, 32'h1);
    check_value("mis_data", reg_data_s, 32'h0);
    check_value("mis_no_req", {31'h0, mem_req_valid_s}, 32'h0);
    tick();
    check_value("mis_pulse", {31'h0, misalign_s}, 32'h0);
`else
    do_load("lw_mis", 3'b010, 32'h5, 32'h01020304, 0, 10'd1, 32'h01020304);
    check_value("mis_tied", {31'h0, misalign_s}, 32'h0);
`endif

    // Reset while waiting for a load response; a later stray response is ignored
    valid_in_s = 1'b1; inst_type_s = LOAD_T; inst_in_s = mk_inst(3'b010, 7'b0000011); addr_s = 32'h8;
    tick();
    valid_in_s = 1'b0; mem_req_ready_s = 1'b1;
    tick();
    mem_req_ready_s = 1'b0;
    #1 check_value("rw_stall_wait", {31'h0, stall_s}, 32'h1);
    reset_s = 1'b1;
    tick();
    reset_s = 1'b0;
    check_value("rw_stall_reset", {31'h0, stall_s}, 32'h0);
    check_value("rw_valid_reset", {31'h0, valid_out_s}, 32'h0);
    mem_rsp_valid_s = 1'b1; mem_rsp_data_s = 32'hDEADBEEF;
    tick();
    mem_rsp_valid_s = 1'b0;
    check_value("rw_stray_valid", {31'h0, valid_out_s}, 32'h0);
    check_value("rw_stray_data", reg_data_s, 32'h0);
    check_value("rw_stall_idle", {31'h0, stall_s}, 32'h0);
    check_value("rw_req_idle", {31'h0, mem_req_valid_s}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
